// File: rtl/junction_pkg.sv
// Shared types and constants for the junction phase scheduler: state encoding,
// default phase durations, the seconds type and the binary-to-BCD helper.
package junction_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GREEN  = 3'd1,
        YELLOW = 3'd2,
        ALLRED = 3'd3,
        WALK   = 3'd4
    } state_e;

    typedef logic [6:0] secs_t;

    localparam int DEF_TICK_DIV = 25_000_000;
    localparam int DEF_GREEN_S  = 20;
    localparam int DEF_YELLOW_S = 3;
    localparam int DEF_ALLRED_S = 2;
    localparam int DEF_WALK_S   = 10;

    // Valid for 0..99; the tens digit is recovered first and the units follow by subtraction.
    function automatic logic [7:0] bin2bcd(input secs_t v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 7'd10);
        units = 4'(v - 7'(tens) * 7'd10);
        return {tens, units};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the board clock down to a one-cycle tick every TICK_DIV cycles;
// clr restarts the count so a new phase always gets full-length seconds.
module tick_prescaler #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/junction_phase_scheduler.sv
// Four-approach intersection phase scheduler: round-robin greens with yellow and
// all-red clearance, latched pedestrian walks, and a BCD countdown of the phase.
module junction_phase_scheduler
    import junction_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int GREEN_S  = DEF_GREEN_S,
    parameter int YELLOW_S = DEF_YELLOW_S,
    parameter int ALLRED_S = DEF_ALLRED_S,
    parameter int WALK_S   = DEF_WALK_S
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ped_req,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic       walk,
    output logic [7:0] remain_bcd,
    output logic       phase_done,
    output state_e     state_dbg
);

    state_e     state;
    state_e     nxt;
    logic [1:0] ptr;
    logic       ped_pending;
    logic       last_walk;
    secs_t      secs;
    secs_t      dur;
    logic       tick;
    logic       phase_end;
    logic       enter;
    logic       clr;
    logic [1:0] arb_idx;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .tick(tick)
    );

    assign phase_end  = (state != IDLE) && tick && (secs == secs_t'(1));
    assign clr        = (state == IDLE) || phase_end;
    assign phase_done = phase_end;
    assign state_dbg  = state;

    // Descending scan so the last hit is the first requester at or after ptr.
    always_comb begin
        arb_idx = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) begin
                arb_idx = ptr + 2'(i);
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (ped_pending || ped_req) begin
                    nxt = WALK;
                end else if (|req) begin
                    nxt = GREEN;
                end
            end
            GREEN:  if (phase_end) nxt = YELLOW;
            YELLOW: if (phase_end) nxt = ALLRED;
            WALK:   if (phase_end) nxt = ALLRED;
            ALLRED: begin
                // A walk is always followed by one vehicle green when there is demand.
                if (phase_end) begin
                    if (last_walk && (|req)) begin
                        nxt = GREEN;
                    end else if (ped_pending) begin
                        nxt = WALK;
                    end else if (|req) begin
                        nxt = GREEN;
                    end else begin
                        nxt = IDLE;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign enter = (nxt != state) && (nxt != IDLE);

    always_comb begin
        case (nxt)
            GREEN:   dur = secs_t'(GREEN_S);
            YELLOW:  dur = secs_t'(YELLOW_S);
            ALLRED:  dur = secs_t'(ALLRED_S);
            WALK:    dur = secs_t'(WALK_S);
            default: dur = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            ped_pending <= 1'b0;
            last_walk   <= 1'b0;
            secs        <= '0;
            remain_bcd  <= 8'h00;
            green       <= '0;
            yellow      <= '0;
            walk        <= 1'b0;
        end else begin
            state <= nxt;

            // A press in the walk-entry cycle is served by that walk.
            if (enter && nxt == WALK) begin
                ped_pending <= 1'b0;
            end else if (ped_req) begin
                ped_pending <= 1'b1;
            end

            if (enter) begin
                secs       <= dur;
                remain_bcd <= bin2bcd(dur);
            end else if (nxt == IDLE) begin
                secs       <= '0;
                remain_bcd <= 8'h00;
            end else if (tick) begin
                secs       <= secs - secs_t'(1);
                remain_bcd <= bin2bcd(secs - secs_t'(1));
            end

            if (enter) begin
                case (nxt)
                    GREEN: begin
                        green     <= 4'b0001 << arb_idx;
                        yellow    <= '0;
                        walk      <= 1'b0;
                        ptr       <= arb_idx + 2'd1;
                        last_walk <= 1'b0;
                    end
                    YELLOW: begin
                        yellow <= green;
                        green  <= '0;
                        walk   <= 1'b0;
                    end
                    WALK: begin
                        walk      <= 1'b1;
                        green     <= '0;
                        yellow    <= '0;
                        last_walk <= 1'b1;
                    end
                    default: begin
                        green  <= '0;
                        yellow <= '0;
                        walk   <= 1'b0;
                    end
                endcase
            end else if (nxt == IDLE) begin
                green     <= '0;
                yellow    <= '0;
                walk      <= 1'b0;
                last_walk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Directed bench for the junction phase scheduler with a short tick so every
// phase sequence can be walked cycle by cycle against hand-derived timing.
module tb_junction_phase_scheduler;
    import junction_pkg::*;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       ped_req = 1'b0;
    logic [3:0] green;
    logic [3:0] yellow;
    logic       walk;
    logic [7:0] remain_bcd;
    logic       phase_done;
    state_e     state_dbg;
    logic [17:0] obs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ped_every = 0;

    junction_phase_scheduler #(
        .TICK_DIV(TD),
        .GREEN_S (3),
        .YELLOW_S(2),
        .ALLRED_S(1),
        .WALK_S  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ped_req   (ped_req),
        .green     (green),
        .yellow    (yellow),
        .walk      (walk),
        .remain_bcd(remain_bcd),
        .phase_done(phase_done),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    assign obs = {green, yellow, walk, remain_bcd, phase_done};

    function automatic logic [17:0] ex(input logic [3:0] g, input logic [3:0] y,
                                       input logic w, input int s, input logic pd);
        logic [7:0] b;
        b[7:4] = 4'(s / 10);
        b[3:0] = 4'(s % 10);
        return {g, y, w, b, pd};
    endfunction

    task automatic chk(input string tag, input logic [17:0] e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        ped_req = (ped_every != 0) && (cyc % ped_every == 0);
    endtask

    task automatic run_phase(input string tag, input logic [3:0] g, input logic [3:0] y,
                             input logic w, input int dur);
        for (int i = 0; i < dur * TD; i++) begin
            step();
            chk(tag, ex(g, y, w, dur - i / TD, i == dur * TD - 1));
        end
    endtask

    task automatic do_reset();
        req       = '0;
        ped_req   = 1'b0;
        ped_every = 0;
        rst       = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // Reset and idle: nothing requested, everything dark.
        do_reset();
        chk("reset_c0", ex(4'b0000, 4'b0000, 1'b0, 0, 1'b0));
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle_quiet", ex(4'b0000, 4'b0000, 1'b0, 0, 1'b0));
        end

        // Single request on approach 2.
        do_reset();
        req = 4'b0100;
        chk("single_c0", ex(4'b0000, 4'b0000, 1'b0, 0, 1'b0));
        run_phase("single_green", 4'b0100, 4'b0000, 1'b0, 3);
        run_phase("single_yellow", 4'b0000, 4'b0100, 1'b0, 2);
        run_phase("single_allred", 4'b0000, 4'b0000, 1'b0, 1);
        step();
        chk("single_regreen", ex(4'b0100, 4'b0000, 1'b0, 3, 1'b0));

        // Round robin over approaches 0, 1 and 3.
        do_reset();
        req = 4'b1011;
        run_phase("rr_green0", 4'b0001, 4'b0000, 1'b0, 3);
        run_phase("rr_yellow0", 4'b0000, 4'b0001, 1'b0, 2);
        run_phase("rr_allred0", 4'b0000, 4'b0000, 1'b0, 1);
        run_phase("rr_green1", 4'b0010, 4'b0000, 1'b0, 3);
        run_phase("rr_yellow1", 4'b0000, 4'b0010, 1'b0, 2);
        run_phase("rr_allred1", 4'b0000, 4'b0000, 1'b0, 1);
        run_phase("rr_green3", 4'b1000, 4'b0000, 1'b0, 3);
        run_phase("rr_yellow3", 4'b0000, 4'b1000, 1'b0, 2);
        run_phase("rr_allred3", 4'b0000, 4'b0000, 1'b0, 1);
        step();
        chk("rr_wrap_green0", ex(4'b0001, 4'b0000, 1'b0, 3, 1'b0));

        // Pedestrian fairness: presses every 20 cycles, walks alternate with greens.
        do_reset();
        req       = 4'b0001;
        ped_every = 20;
        ped_req   = 1'b1;
        run_phase("ped_walk1", 4'b0000, 4'b0000, 1'b1, 2);
        run_phase("ped_allred1", 4'b0000, 4'b0000, 1'b0, 1);
        run_phase("ped_green1", 4'b0001, 4'b0000, 1'b0, 3);
        run_phase("ped_yellow1", 4'b0000, 4'b0001, 1'b0, 2);
        run_phase("ped_allred2", 4'b0000, 4'b0000, 1'b0, 1);
        run_phase("ped_walk2", 4'b0000, 4'b0000, 1'b1, 2);
        run_phase("ped_allred3", 4'b0000, 4'b0000, 1'b0, 1);
        run_phase("ped_green2", 4'b0001, 4'b0000, 1'b0, 3);
        run_phase("ped_yellow2", 4'b0000, 4'b0001, 1'b0, 2);
        run_phase("ped_allred4", 4'b0000, 4'b0000, 1'b0, 1);
        run_phase("ped_walk3", 4'b0000, 4'b0000, 1'b1, 2);

        // A press only in the walk-entry cycle is consumed by that walk.
        do_reset();
        ped_req = 1'b1;
        run_phase("absorb_walk", 4'b0000, 4'b0000, 1'b1, 2);
        run_phase("absorb_allred", 4'b0000, 4'b0000, 1'b0, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("absorb_idle", ex(4'b0000, 4'b0000, 1'b0, 0, 1'b0));
        end

        // Asynchronous reset in the middle of a green.
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("arst_green", ex(4'b0001, 4'b0000, 1'b0, 3 - i / TD, 1'b0));
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_dark", ex(4'b0000, 4'b0000, 1'b0, 0, 1'b0));
        #1;
        rst = 1'b0;
        step();
        chk("arst_regreen", ex(4'b0001, 4'b0000, 1'b0, 3, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/junction_phase_scheduler.md
# junction_phase_scheduler

Four-approach intersection phase scheduler that shares the junction's right-of-way among vehicle approaches and a pedestrian crossing. Sits above the lamp drivers and the seven-segment display path, generating one-second ticks from the board clock. It grants round-robin greens, inserts yellow and all-red clearance, and services latched pedestrian requests. It also exports the remaining seconds of the current phase as two BCD digits for the display decoders.

## Interface
- TICK_DIV, 25_000_000: clk cycles per one-second tick; legal range ≥2.
- GREEN_S, 20: green duration, seconds; legal range 1..99.
- YELLOW_S, 3: yellow duration, seconds; legal range 1..99.
- ALLRED_S, 2: all-red clearance, seconds; legal range 1..99.
- WALK_S, 10: pedestrian walk duration, seconds; legal range 1..99.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- req  in  4  vehicle demand per approach, level, synchronous to clk.
- ped_req  in  1  pedestrian button, synchronous to clk; any high cycle is latched.
- green  out  4  one-hot green lamp, or all zero.
- yellow  out  4  one-hot yellow lamp, or all zero.
- walk  out  1  pedestrian walk lamp.
- remain_bcd  out  8  seconds left in the current phase as two BCD digits: [7:4] tens, [3:0] units.
- phase_done  out  1  one-cycle pulse on the last cycle of every timed phase.

## Operation
- Reset values:
  - State: IDLE.
  - green=0, yellow=0, walk=0, remain_bcd=8'h00, phase_done=0.
  - Round-robin pointer=0, ped_pending=0, last_walk=0.
- States: IDLE, GREEN, YELLOW, ALLRED, WALK. Red is implied for any approach without green or yellow.
- ped_pending:
  - Set by ped_req=1.
  - Cleared on entry to WALK.
  - If ped_req is high in the same cycle as WALK entry, it is absorbed and the flag stays 0.
- Arbitration:
  - Scan req starting at index ptr, wrapping 3→0.
  - The first set bit wins, and ptr becomes winner+1 mod 4.
- IDLE:
  - Each cycle: if ped_pending or ped_req, go to WALK.
  - Otherwise, if any req bit is set, go to GREEN for the arbitration winner.
  - Otherwise, stay in IDLE.
- GREEN(a) → YELLOW(a) → ALLRED. Each phase lasts its full duration regardless of req changes during it.
- WALK → ALLRED. On WALK entry, set last_walk=1.
- At the end of ALLRED:
  - If last_walk=1 and any req is set: go to GREEN and clear last_walk. Vehicles get one green before a second walk, which prevents pedestrian starvation.
  - Else if ped_pending: go to WALK.
  - Else if any req is set: go to GREEN.
  - Else: go to IDLE and clear last_walk.
- Phase timer:
  - On phase entry, the seconds counter loads the phase duration and the tick prescaler clears.
  - On each tick, if seconds==1 the phase ends; otherwise seconds decrements.
  - remain_bcd is the BCD of seconds in timed states and 8'h00 in IDLE.
- phase_done is high in the final cycle of GREEN, YELLOW, ALLRED and WALK. It is never high in IDLE.
- Reset mid-phase returns to the reset values immediately. Lamps go dark, which means all-red.

## Timing
- Prescaler:
  - Counts 0..TICK_DIV-1 and ticks when the count equals TICK_DIV-1.
  - Cleared in the cycle of each phase entry.
- A timed phase of D seconds occupies exactly D×TICK_DIV cycles.
- IDLE exit latency: a request seen in cycle t produces lamp output in cycle t+1. All outputs are registered.
- Back-to-back phases have no gap cycle. The next phase's lamp is asserted in the cycle after phase_done.
- remain_bcd updates in the cycle after the tick, together with the decremented count.
- green, yellow and walk are mutually exclusive in every cycle. At most one bit of green|yellow is set.

## Structure
- Shared package `junction_pkg` holds:
  - the state enum: IDLE=0, GREEN=1, YELLOW=2, ALLRED=3, WALK=4, 3 bits;
  - the default duration constants;
  - a 7-bit seconds type.
- Sub-module `tick_prescaler`:
  - Parameter: TICK_DIV.
  - Ports: clk, rst, clr, tick.
  - Instantiated once.
- Binary-to-BCD conversion (0..99) is a function in `junction_pkg`.

## Test plan
All scenarios use TICK_DIV=4, GREEN_S=3, YELLOW_S=2, ALLRED_S=1, WALK_S=2.
- Reset/idle: rst pulse with no requests → all outputs stay 0 for 100 cycles.
- Single request: req=4'b0100 held from cycle 0 →
  - green=4'b0100 in cycles 1–12, with remain_bcd stepping 03,02,01;
  - yellow=4'b0100 in cycles 13–20;
  - all-red in cycles 21–24;
  - green=4'b0100 again in cycle 25.
- Round-robin: req=4'b1011 held → green order 0,1,3,0. Each green is separated by 8 yellow cycles and 4 all-red cycles.
- Pedestrian fairness: ped_req pulses every 20 cycles while req=4'b0001 → the sequence alternates WALK, GREEN(0), WALK. Two walks are never adjacent.
- Absorbed press: ped_req high on the WALK entry cycle only → no second WALK follows.
- Async reset mid-GREEN: rst asserted between clock edges at cycle 6 → green=0 and remain_bcd=00 immediately. After release with req still set, green reasserts with remain_bcd=03.
